func_unit_sched: RTL
====================

Name: func_unit_sched

Overview:
- Round-robin scheduler that shares one registered function unit between 4 requesters.
- The unit performs four operations: 4-bit add with carry-in, 4:1 bit mux, 4:2 one-hot encoder, and 4-bit magnitude compare.
- The block arbitrates, latches the winner's operands, executes once, and returns a tagged result through a valid/ready response port.
- It sits between requesting control blocks and the shared arithmetic resource, so only one instance of the unit is needed.

Parameters:
- NREQ, 4, number of requesters (fixed at 4 for this revision; the pointer is 2 bits).
- DW, 4, operand width in bits (result width is DW+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  per-requester request; bit i = requester i.
- op  input  8  op[2i+1:2i] = opcode of requester i.
- opa  input  16  opa[4i+3:4i] = operand A of requester i.
- opb  input  16  opb[4i+3:4i] = operand B of requester i.
- cin  input  4  carry-in of requester i (used by ADD only).
- gnt  output  4  one-hot, one-cycle grant pulse.
- busy  output  1  high whenever state != IDLE.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  2  index of the requester that owns the result.
- result  output  5  function output.
- err  output  1  ENC input was not one-hot; valid with resp_valid.

Behaviour:
- All outputs are registered. The clock is clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at an edge) sets: state=IDLE, gnt=0, busy=0, resp_valid=0, resp_id=0, result=0, err=0, rr_ptr=0 (requester 0 highest priority).
  - Reset mid-operation aborts any in-flight op; no response is produced for it.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If req != 0 at an edge: pick the first set bit searching from rr_ptr upward, modulo 4.
  - Latch that requester's op, opa, opb, cin and its id; set gnt to that bit only; go to EXEC.
  - If req == 0, stay in IDLE.
- EXEC (one cycle, gnt high):
  - At the edge, compute on the latched operands and register result/err.
  - Set resp_valid=1, gnt=0, go to RESP.
- RESP:
  - Hold result, resp_id, err and resp_valid stable until resp_ready=1 at an edge.
  - At that edge: resp_valid=0, rr_ptr=(granted id+1) mod 4, go to IDLE.
  - If resp_ready is already high on the first RESP cycle, the response completes in one cycle.
- Latency:
  - Request sampled at edge N; gnt high in cycle N+1; resp_valid high from cycle N+2.
  - Minimum issue interval is 3 cycles, because a new arbitration starts in IDLE.
- Requester rules:
  - A requester holds req, op and operands stable until it sees gnt, then may drop req.
  - Operands are captured at the grant edge, so later changes are ignored.
  - A req still high after its grant is treated as a new request.
- Requests arriving while busy are not lost. They are simply not sampled until IDLE; no queueing beyond the req level.
- Operations (a=opa, b=opb, unsigned):
  - 00 ADD: result = a + b + cin, full 5-bit result; the carry is result[4]. No wrap inside 5 bits: max 15+15+1=31.
  - 01 MUX: result = {4'b0, a[b[1:0]]}; b[3:2] ignored.
  - 10 ENC: a=0001->0, 0010->1, 0100->2, 1000->3, result zero-extended.
    - Any other a, including 0 and multi-hot: result=0, err=1.
    - err=0 for every other op.
  - 11 CMP: result = {2'b0, a>b, a==b, a<b}; exactly one of result[2:0] is set.
- Round-robin fairness: with all 4 requesting continuously, grants go 0,1,2,3,0,...
  - Any requester waits at most 3 other grants.

Test Plan:
- Reset then single request: req=0001, op0=ADD, a=5, b=15, cin=1 -> gnt=0001 one cycle later; resp_valid two cycles after sampling; result=21 (10101), resp_id=0, err=0.
- CMP and MUX: requester 2 CMP a=9, b=12 -> result=00001 (lt). Requester 1 MUX a=0101, b=10 -> result=1. Requester 3 CMP a=7, b=7 -> result=00010.
- ENC: a=0100 -> result=2, err=0. a=0110 -> result=0, err=1. A following ADD -> err=0.
- Round robin: req=1111 held with all ops ADD, resp_ready=1 -> gnt order 0001, 0010, 0100, 1000, 0001, with a new grant every 3 cycles. Then req=1010 after the requester-1 grant -> next gnt=1000.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> result/resp_id stable, no gnt, busy=1. Raising resp_ready -> resp_valid drops next edge and the next grant follows.
- Reset mid-op: rst_n=0 during EXEC -> next edge gnt=0, resp_valid=0, busy=0, rr_ptr=0. A pending req=1000 is then granted normally.

Source files
------------

// File: rtl/func_unit_sched_if.sv
// Request/response bundle between the requesting control blocks and the shared
// function-unit scheduler.
interface func_unit_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    localparam int IDW = 2;

    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [DW*NREQ-1:0] opa;
    logic [DW*NREQ-1:0] opb;
    logic [NREQ-1:0]    cin;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [DW:0]        result;
    logic               err;

    modport master (
        output req, op, opa, opb, cin, resp_ready,
        input  gnt, busy, resp_valid, resp_id, result, err
    );

    modport slave (
        input  req, op, opa, opb, cin, resp_ready,
        output gnt, busy, resp_valid, resp_id, result, err
    );
endinterface

// File: rtl/func_unit_sched.sv
// Round-robin scheduler sharing one registered ADD/MUX/ENC/CMP unit between four
// requesters; results return tagged with the owner id over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate from rr_ptr and latch the winner
// EXEC  | grant pulse high; compute on latched operands at the next edge
// RESP  | resp_valid high; hold result until resp_ready, then advance rr_ptr
module func_unit_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4
) (
    input logic              clk,
    input logic              rst_n,
    func_unit_sched_if.slave bus
);
    localparam int IDW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUX = 2'b01,
        OP_ENC = 2'b10,
        OP_CMP = 2'b11
    } opcode_t;

    state_t          state, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [DW:0]     result_q, result_d;
    logic            err_q, err_d;
    logic [IDW-1:0]  rr_ptr, rr_ptr_d;

    logic [1:0]      lat_op, lat_op_d;
    logic [DW-1:0]   lat_a, lat_a_d;
    logic [DW-1:0]   lat_b, lat_b_d;
    logic            lat_cin, lat_cin_d;
    logic [IDW-1:0]  lat_id, lat_id_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;

    logic [DW:0]     alu_res;
    logic            alu_err;

    // First set request at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDW'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        unique case (opcode_t'(lat_op))
            OP_ADD: alu_res = {1'b0, lat_a} + {1'b0, lat_b} + {{DW{1'b0}}, lat_cin};
            OP_MUX: alu_res = {{DW{1'b0}}, lat_a[lat_b[1:0]]};
            OP_ENC: begin
                case (lat_a)
                    4'b0001: alu_res = (DW+1)'(0);
                    4'b0010: alu_res = (DW+1)'(1);
                    4'b0100: alu_res = (DW+1)'(2);
                    4'b1000: alu_res = (DW+1)'(3);
                    default: alu_err = 1'b1;
                endcase
            end
            OP_CMP: alu_res = {{(DW-2){1'b0}}, lat_a > lat_b, lat_a == lat_b, lat_a < lat_b};
        endcase
    end

    always_comb begin
        state_d      = state;
        gnt_d        = gnt_q;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        result_d     = result_q;
        err_d        = err_q;
        rr_ptr_d     = rr_ptr;
        lat_op_d     = lat_op;
        lat_a_d      = lat_a;
        lat_b_d      = lat_b;
        lat_cin_d    = lat_cin;
        lat_id_d     = lat_id;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d   = EXEC;
                    gnt_d     = NREQ'(1) << pick_id;
                    busy_d    = 1'b1;
                    lat_op_d  = bus.op[2*pick_id +: 2];
                    lat_a_d   = bus.opa[DW*pick_id +: DW];
                    lat_b_d   = bus.opb[DW*pick_id +: DW];
                    lat_cin_d = bus.cin[pick_id];
                    lat_id_d  = pick_id;
                end
            end
            EXEC: begin
                state_d      = RESP;
                gnt_d        = '0;
                resp_valid_d = 1'b1;
                resp_id_d    = lat_id;
                result_d     = alu_res;
                err_d        = alu_err;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    rr_ptr_d     = lat_id + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            rr_ptr       <= '0;
            lat_op       <= '0;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_cin      <= 1'b0;
            lat_id       <= '0;
        end else begin
            state        <= state_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            result_q     <= result_d;
            err_q        <= err_d;
            rr_ptr       <= rr_ptr_d;
            lat_op       <= lat_op_d;
            lat_a        <= lat_a_d;
            lat_b        <= lat_b_d;
            lat_cin      <= lat_cin_d;
            lat_id       <= lat_id_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.result     = result_q;
    assign bus.err        = err_q;
endmodule
